// File: rtl/ram_ecc_pkg.sv
// Shared types and constants for the ECC RAM scrubber and the RAM it drives.
package ram_ecc_pkg;
  localparam int ECC_ERR_W      = 2;
  localparam int RAM_DATA_WIDTH = 8;
  localparam int RAM_ADDR_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    USER_RD,
    SCRUB_RD,
    SCRUB_CHK,
    SCRUB_WB
  } scrub_state_e;
endpackage

// File: rtl/ram_ecc_scrubber_sat_counter.sv
// Saturating up-counter used for the scrub error statistics.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 q <= '0;
    else if (clr)               q <= '0;
    else if (inc && (q != '1))  q <= q + 1'b1;
  end
endmodule

// File: rtl/ram_ecc_scrubber.sv
// Arbiter between user accesses and a background ECC scrub engine for ram_with_ecc.
// Optional SCRUB_ERR_LOG_EN keeps the address of the last scrub error in err_addr.
module ram_ecc_scrubber
  import ram_ecc_pkg::*;
#(
  parameter int DATA_WIDTH     = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH     = RAM_ADDR_WIDTH,
  parameter int SCRUB_INTERVAL = 256,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  user_req,
  input  logic                  user_we,
  input  logic [ADDR_WIDTH-1:0] user_addr,
  input  logic [DATA_WIDTH-1:0] user_din,
  output logic                  user_ready,
  output logic                  user_rvalid,
  output logic [DATA_WIDTH-1:0] user_rdata,
  output logic [ECC_ERR_W-1:0]  user_err,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic                  ram_sbe,
  input  logic                  ram_dbe,
  input  logic                  scrub_en,
  output logic                  scrub_busy,
  output logic                  sweep_done,
  output logic [CNT_WIDTH-1:0]  corr_cnt,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt,
  output logic [ADDR_WIDTH-1:0] err_addr
);
  localparam logic [15:0]           TIMER_LAST = 16'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST   = '1;

  scrub_state_e          state, state_nxt;
  logic [15:0]           timer;
  logic                  scrub_pend;
  logic [ADDR_WIDTH-1:0] ptr, addr_q;
  logic [DATA_WIDTH-1:0] din_q, wb_data;
  logic                  user_acc, ptr_adv, corr_inc, uncorr_inc;

  // rst_n gating keeps the RAM strobes quiet while reset is held
  assign user_ready = rst_n && (state == IDLE) && !scrub_pend;
  assign user_acc   = user_req && user_ready;
  assign scrub_busy = (state == SCRUB_RD) || (state == SCRUB_CHK) || (state == SCRUB_WB);

  always_comb begin
    state_nxt   = state;
    ram_we      = 1'b0;
    ram_addr    = addr_q;
    ram_din     = din_q;
    user_rvalid = 1'b0;
    user_rdata  = '0;
    user_err    = '0;
    ptr_adv     = 1'b0;
    corr_inc    = 1'b0;
    uncorr_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (scrub_pend) begin
          state_nxt = SCRUB_RD;
        end else if (user_acc) begin
          ram_addr = user_addr;
          if (user_we) begin
            ram_we  = 1'b1;
            ram_din = user_din;
          end else begin
            state_nxt = USER_RD;
          end
        end
      end
      USER_RD: begin
        user_rvalid = 1'b1;
        user_rdata  = ram_dout;
        user_err    = {ram_dbe, ram_sbe};
        state_nxt   = IDLE;
      end
      SCRUB_RD: begin
        ram_addr  = ptr;
        state_nxt = SCRUB_CHK;
      end
      SCRUB_CHK: begin
        if (ram_dbe) begin
          uncorr_inc = 1'b1;
          ptr_adv    = 1'b1;
          state_nxt  = IDLE;
        end else if (ram_sbe) begin
          state_nxt = SCRUB_WB;
        end else begin
          ptr_adv   = 1'b1;
          state_nxt = IDLE;
        end
      end
      SCRUB_WB: begin
        ram_we    = 1'b1;
        ram_addr  = ptr;
        ram_din   = wb_data;
        corr_inc  = 1'b1;
        ptr_adv   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      scrub_pend <= 1'b0;
      ptr        <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr_q     <= ram_addr;
      din_q      <= ram_din;
      sweep_done <= ptr_adv && (ptr == PTR_LAST);
      if (ptr_adv) ptr <= ptr + 1'b1;
      if ((state == IDLE) && scrub_en) begin
        if (timer == TIMER_LAST) timer <= '0;
        else                     timer <= timer + 1'b1;
      end
      if (!scrub_en || (state_nxt == SCRUB_RD))
        scrub_pend <= 1'b0;
      else if ((state == IDLE) && (timer == TIMER_LAST))
        scrub_pend <= 1'b1;
    end
  end

  // Corrected word captured for re-encoding on the writeback cycle
  always_ff @(posedge clk) begin
    if ((state == SCRUB_CHK) && ram_sbe && !ram_dbe) wb_data <= ram_dout;
  end

`ifdef SCRUB_ERR_LOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        err_addr <= '0;
    else if ((state == SCRUB_CHK) && (ram_sbe || ram_dbe)) err_addr <= ptr;
  end
`else
  assign err_addr = '0;
`endif

  sat_counter #(.WIDTH(CNT_WIDTH)) u_corr_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (corr_inc),
    .clr  (1'b0),
    .q    (corr_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_uncorr_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (uncorr_inc),
    .clr  (1'b0),
    .q    (uncorr_cnt)
  );
endmodule

// File: tb/tb_ram_ecc_scrubber.sv
// Bench for ram_ecc_scrubber: ECC RAM model, per-visit scrub model and directed scenarios.
module tb_ram_ecc_scrubber;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 2;
  localparam int NW = 16;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          user_req, user_we;
  logic [AW-1:0] user_addr;
  logic [DW-1:0] user_din;
  logic          user_ready, user_rvalid;
  logic [DW-1:0] user_rdata;
  logic [1:0]    user_err;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_sbe, ram_dbe;
  logic          scrub_en, scrub_busy, sweep_done;
  logic [CW-1:0] corr_cnt, uncorr_cnt;
  logic [AW-1:0] err_addr;

  int tests = 0;
  int fails = 0;

  ram_ecc_scrubber #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SCRUB_INTERVAL(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .user_req(user_req), .user_we(user_we), .user_addr(user_addr),
    .user_din(user_din), .user_ready(user_ready), .user_rvalid(user_rvalid), .user_rdata(user_rdata),
    .user_err(user_err), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_sbe(ram_sbe), .ram_dbe(ram_dbe), .scrub_en(scrub_en), .scrub_busy(scrub_busy),
    .sweep_done(sweep_done), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // ECC RAM model: true data plus an injected flip mask per word
  logic [DW-1:0] mem   [NW];
  logic [DW-1:0] flips [NW];
  logic          inj_req = 1'b0;
  logic [AW-1:0] inj_addr = '0;
  logic [DW-1:0] inj_mask = '0;

  always @(posedge clk) begin
    ram_sbe  <= ($countones(flips[ram_addr]) == 1);
    ram_dbe  <= ($countones(flips[ram_addr]) >= 2);
    ram_dout <= ($countones(flips[ram_addr]) >= 2) ? (mem[ram_addr] ^ flips[ram_addr]) : mem[ram_addr];
    if (ram_we) begin
      mem[ram_addr]   <= ram_din;
      flips[ram_addr] <= '0;
    end else if (inj_req) begin
      flips[inj_addr] <= inj_mask;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard state: user data shadow and the expected outcome of each scrub visit
  logic [DW-1:0] exp_mem [NW];
  int            sp, exp_sweeps, seen_sweeps, idle_run;
  logic [CW-1:0] exp_corr, exp_unc;
  logic [AW-1:0] exp_ea, wb_addr, rd_addr, prev_addr;
  logic [DW-1:0] prev_din;
  logic          wb_pend, rd_prev, prev_busy;
  logic [1:0]    rd_err;

  initial begin
    logic acc;
    int   pc;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outs_a", {user_ready, user_rvalid, user_rdata, user_err, ram_we, ram_addr, ram_din}, 0);
        chk("reset_outs_b", {scrub_busy, sweep_done, corr_cnt, uncorr_cnt, err_addr}, 0);
        sp = 0; exp_sweeps = 0; seen_sweeps = 0; idle_run = 0;
        exp_corr = '0; exp_unc = '0; exp_ea = '0; wb_pend = 1'b0; rd_prev = 1'b0;
        prev_busy = 1'b0; prev_addr = '0; prev_din = '0;
      end else begin
        acc = user_req && user_ready;
        chk("rvalid_timing", user_rvalid, rd_prev);
        if (rd_prev && user_rvalid) begin
          chk("rd_err", user_err, rd_err);
          if (!rd_err[1]) chk("rd_data", user_rdata, exp_mem[rd_addr]);
        end
        if (scrub_busy || rd_prev) chk("ready_low", user_ready, 0);
        if (scrub_busy && !prev_busy) begin
          chk("visit_addr", ram_addr, sp);
          chk("visit_no_we", ram_we, 0);
          pc = $countones(flips[sp]);
          if (pc >= 2) begin
            if (exp_unc != CMAX) exp_unc = exp_unc + 1'b1;
            exp_ea = AW'(sp);
          end else if (pc == 1) begin
            if (exp_corr != CMAX) exp_corr = exp_corr + 1'b1;
            exp_ea  = AW'(sp);
            wb_pend = 1'b1;
            wb_addr = AW'(sp);
          end
          sp = (sp + 1) % NW;
          if (sp == 0) exp_sweeps++;
        end
        if (ram_we) begin
          if (acc && user_we) begin
            chk("wr_addr", ram_addr, user_addr);
            chk("wr_data", ram_din, user_din);
          end else begin
            chk("wb_expected", {scrub_busy, wb_pend}, 2'b11);
            chk("wb_addr", ram_addr, wb_addr);
            chk("wb_data", ram_din, exp_mem[wb_addr]);
            wb_pend = 1'b0;
          end
        end else if (!acc && !scrub_busy) begin
          chk("addr_hold", {ram_addr, ram_din}, {prev_addr, prev_din});
        end
        if (sweep_done) seen_sweeps++;
        idle_run = scrub_busy ? 0 : idle_run + 1;
        if (idle_run >= 2) begin
          chk("corr_cnt", corr_cnt, exp_corr);
          chk("uncorr_cnt", uncorr_cnt, exp_unc);
          chk("sweeps", seen_sweeps, exp_sweeps);
          chk("wb_missing", wb_pend, 0);
`ifdef SCRUB_ERR_LOG_EN
          chk("err_addr", err_addr, exp_ea);
`else
          chk("err_addr", err_addr, 0);
`endif
        end
        rd_prev = acc && !user_we;
        if (rd_prev) begin
          rd_addr = user_addr;
          pc      = $countones(flips[user_addr]);
          rd_err  = {pc >= 2, pc == 1};
        end
        prev_busy = scrub_busy;
        prev_addr = ram_addr;
        prev_din  = ram_din;
      end
    end
  end

  task automatic wait_ready(output int waited);
    waited = 0;
    @(negedge clk);
    while (!user_ready && waited < 500) begin
      waited++;
      @(negedge clk);
    end
    if (!user_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int w;
    user_req = 1'b1; user_we = 1'b1; user_addr = a; user_din = d;
    wait_ready(w);
    exp_mem[a] = d;
    @(posedge clk); #1;
    user_req = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] e,
                         output int waited);
    user_req = 1'b1; user_we = 1'b0; user_addr = a;
    wait_ready(waited);
    @(posedge clk); #1;
    user_req = 1'b0;
    @(negedge clk);
    chk("rd_pulse", user_rvalid, 1);
    d = user_rdata;
    e = user_err;
    @(posedge clk); #1;
  endtask

  task automatic inject(input logic [AW-1:0] a, input logic [DW-1:0] m);
    inj_addr = a; inj_mask = m; inj_req = 1'b1;
    @(posedge clk); #1;
    inj_req = 1'b0;
  endtask

  task automatic wait_sweeps(input int n);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (sweep_done) got++;
    end
    if (got < n) chk("sweep_timeout", got, n);
    @(posedge clk); #1;
  endtask

  task automatic wait_corr(input logic [CW-1:0] target);
    int cyc = 0;
    @(negedge clk);
    while (corr_cnt != target && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    if (corr_cnt != target) chk("corr_timeout", corr_cnt, target);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [1:0]    e;
    int            w, cyc;
    rst_n = 1'b0; user_req = 1'b0; user_we = 1'b0; user_addr = '0; user_din = '0; scrub_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NW; i++) do_write(AW'(i), 8'(i * 17) ^ 8'h3C);
    do_write(4'd3, 8'hA5);
    do_read(4'd3, d, e, w);
    chk("lit_rd3_data", d, 8'hA5);
    chk("lit_rd3_err", e, 2'b00);

    inject(4'd5, 8'h04);
    scrub_en = 1'b1;
    wait_corr(2'd1);
    chk("lit_corr1", corr_cnt, 1);
    chk("lit_fixed5_mask", flips[5], 0);
    chk("lit_fixed5_data", mem[5], 8'h69);
    wait_sweeps(2);
    chk("lit_corr_stays1", corr_cnt, 1);

    inject(4'd7, 8'h81);
    cyc = 0;
    while (uncorr_cnt == 0 && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("lit_uncorr1", uncorr_cnt, 1);
    repeat (3) @(negedge clk);
    chk("lit_no_wb7", flips[7], 8'h81);
`ifdef SCRUB_ERR_LOG_EN
    chk("lit_err_addr7", err_addr, 7);
`endif
    @(posedge clk); #1;
    do_write(4'd7, 8'h77);

    inject(4'd1, 8'h01); inject(4'd2, 8'h02); inject(4'd3, 8'h40); inject(4'd4, 8'h08);
    wait_sweeps(2);
    chk("lit_corr_sat", corr_cnt, 3);
    chk("lit_uncorr_hold", uncorr_cnt, 1);

    wait_sweeps(1);
    cyc = 0;
    while (!scrub_busy && cyc < 100) begin @(negedge clk); cyc++; end
    chk("lit_wrap_to_0", ram_addr, 0);

    cyc = 0;
    while (!scrub_busy && cyc < 100) begin @(negedge clk); cyc++; end
    @(posedge clk); #1;
    do_read(4'd9, d, e, w);
    chk("lit_blocked", (w >= 1), 1);
    chk("lit_rd9_data", d, 8'hA5);
    chk("lit_rd9_err", e, 2'b00);

    inject(4'd10, 8'h10);
    cyc = 0;
    @(negedge clk);
    while (!(ram_we && scrub_busy && ram_addr == 4'd10) && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("lit_wb10_seen", {ram_we, scrub_busy}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("lit_rst_we", ram_we, 0);
    chk("lit_rst_cnt", {corr_cnt, uncorr_cnt}, 0);
    chk("lit_rst_busy", scrub_busy, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("lit_no_partial", flips[10], 8'h10);
    wait_corr(2'd1);
    chk("lit_fixed10", flips[10], 0);

    scrub_en = 1'b0;
    repeat (6) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ram_ecc_scrubber.md
Name: ram_ecc_scrubber

Overview:
Controller placed directly upstream of the ECC-protected single-port RAM (ram_with_ecc) and the only block that drives its we/addr/din.
- Arbitrates user read/write requests against a background scrub engine.
- The scrub engine periodically reads each word, checks the RAM's error flags, and writes back words flagged single_bit_error so the RAM re-encodes them.
- Reports scrub statistics to software.

Parameters:
DATA_WIDTH, 8, data word width; must match the RAM.
ADDR_WIDTH, 4, address width; the RAM holds 2**ADDR_WIDTH words.
SCRUB_INTERVAL, 256, idle cycles between scrub reads; legal range 2..65535.
CNT_WIDTH, 8, width of the saturating error counters.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst_n  in  1  asynchronous active-low reset.
user_req  in  1  user access request.
user_we  in  1  1 = write, 0 = read; qualified by user_req.
user_addr  in  ADDR_WIDTH  user address.
user_din  in  DATA_WIDTH  user write data.
user_ready  out  1  request accepted this cycle when user_req && user_ready.
user_rvalid  out  1  read data valid; a single-cycle pulse.
user_rdata  out  DATA_WIDTH  read data; valid only with user_rvalid.
user_err  out  2  {double, single} error flags of the read; valid only with user_rvalid.
ram_we  out  1  to RAM we.
ram_addr  out  ADDR_WIDTH  to RAM addr.
ram_din  out  DATA_WIDTH  to RAM din.
ram_dout  in  DATA_WIDTH  from RAM dout; registered in the RAM, 1-cycle read latency.
ram_sbe  in  1  from RAM single_bit_error; same timing as ram_dout.
ram_dbe  in  1  from RAM double_bit_error; same timing as ram_dout.
scrub_en  in  1  enables the background scrub engine.
scrub_busy  out  1  scrub sequence in progress.
sweep_done  out  1  1-cycle pulse after the last address is scrubbed.
corr_cnt  out  CNT_WIDTH  count of scrub writebacks; saturates.
uncorr_cnt  out  CNT_WIDTH  count of scrub double errors; saturates.
err_addr  out  ADDR_WIDTH  see Optional Feature.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; timer, scrub pointer and both counters =0.
  - All outputs 0, including ram_we. Any in-flight scrub or writeback is abandoned.
- FSM states: IDLE, USER_RD, SCRUB_RD, SCRUB_CHK, SCRUB_WB.
- Timer:
  - Increments in IDLE while scrub_en=1; holds when scrub_en=0.
  - Reaching SCRUB_INTERVAL-1 sets scrub_pend and clears the timer.
  - scrub_pend clears when SCRUB_RD is entered, or when scrub_en=0.
- user_ready = (state==IDLE) && !scrub_pend. Scrub takes priority to bound scrub latency.
- User write accepted:
  - Same cycle: ram_we=1, ram_addr=user_addr, ram_din=user_din.
  - Stays in IDLE, so back-to-back writes run at 1/cycle.
- User read accepted:
  - ram_addr=user_addr with ram_we=0, then go to USER_RD.
  - In USER_RD: user_rvalid=1, user_rdata=ram_dout, user_err={ram_dbe,ram_sbe}; then return to IDLE.
  - Read throughput is 1 per 2 cycles.
- Scrub path:
  - IDLE with scrub_pend goes to SCRUB_RD: ram_addr=ptr, ram_we=0.
  - SCRUB_RD goes to SCRUB_CHK, where ram_dout and the flags are sampled:
    - ram_dbe=1: uncorr_cnt++, no writeback, go to IDLE.
    - ram_sbe=1 (and dbe=0): latch ram_dout, go to SCRUB_WB.
    - Otherwise: go to IDLE.
  - SCRUB_WB: ram_we=1, ram_addr=ptr, ram_din=latched data, corr_cnt++, go to IDLE.
  - The pointer advances on leaving SCRUB_CHK or SCRUB_WB.
  - At 2**ADDR_WIDTH-1 the pointer wraps to 0 and sweep_done pulses.
- scrub_busy = state in {SCRUB_RD, SCRUB_CHK, SCRUB_WB}.
- A scrub sequence is atomic. Deasserting scrub_en mid-sequence completes the current word.
- Counters saturate at 2**CNT_WIDTH-1; there is no wrap.
- A user write to ptr's address while scrub_pend is set is fine: the scrub reads the new data.
- Outside active cycles, ram_we=0 and ram_addr/ram_din hold their last value.

Optional Feature:
SCRUB_ERR_LOG_EN
- Defined: err_addr is a register loaded with ptr on every scrub single or double error (last-error address); reset value 0.
- Undefined: err_addr is tied to 0 and no flop is generated.

Decomposition:
- Package ram_ecc_pkg:
  - scrub_state_e enum (IDLE, USER_RD, SCRUB_RD, SCRUB_CHK, SCRUB_WB).
  - Constant ECC_ERR_W=2.
  - Default DATA_WIDTH/ADDR_WIDTH constants shared with the RAM.
- Sub-module sat_counter (parameter WIDTH; inc, clr, q), instantiated twice for corr_cnt and uncorr_cnt.

Test Plan:
- Reset then write 0xA5 to addr 3; read addr 3 -> user_rvalid one cycle after accept, user_rdata=0xA5, user_err=2'b00.
- Bench RAM model: flip one stored bit at addr 5, scrub_en=1, SCRUB_INTERVAL=4 -> SCRUB_WB writes addr 5; corr_cnt=1; next scrub of addr 5 reports no error.
- Inject a double error at addr 7 -> uncorr_cnt=1, no ram_we to addr 7, err_addr=7 with SCRUB_ERR_LOG_EN.
- Full sweep, 16 words, no errors -> sweep_done pulses exactly once after ptr=15; ptr wraps to 0.
- user_req held while scrub_pend rises -> user_ready=0 until the scrub returns to IDLE; request then accepted with data intact.
- Assert rst_n=0 during SCRUB_WB -> ram_we drops immediately; counters=0, state=IDLE; no partial write observed after release.
